div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle iterative divider for RV32M DIV, DIVU, REM and REMU.
- Sits beside the combinational EX-stage ALU and replaces its single-cycle divide path.
- The EX stage is the initiator: it issues one operation with START, stalls the pipeline while BUSY is high, and captures RESULT when DONE pulses.
- Implements a radix-2 restoring algorithm, one quotient bit per cycle, with the RISC-V special-case results.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request strobe; accepted only in IDLE.
- OP  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- DATA1  input  WIDTH  dividend; sampled on the accept edge.
- DATA2  input  WIDTH  divisor; sampled on the accept edge.
- KILL  input  1  pipeline flush; aborts any operation in flight.
- BUSY  output  1  high whenever the state is not IDLE.
- DONE  output  1  one-cycle pulse; RESULT is valid while DONE is high.
- RESULT  output  WIDTH  quotient or remainder; held until the next accept.

Behaviour:
- Reset: RESET sampled high on an edge forces state IDLE, BUSY=0, DONE=0, RESULT=0, counter=0 and all internal registers to 0. This applies regardless of state, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- Accept: the edge where state=IDLE, START=1 and KILL=0. On that edge, OP, DATA1 and DATA2 are latched. START in any other state is ignored and not queued.
- Signed ops (DIV, REM):
  - Operands are converted to magnitudes on accept.
  - Quotient sign = sign(DATA1) XOR sign(DATA2).
  - Remainder sign = sign(DATA1).
- Special cases, checked on the accept edge; both go IDLE->DONE directly with RESULT loaded, so DONE is high in the cycle after accept (latency 1):
  - Divide by zero (DATA2=0): DIV/DIVU give all ones; REM/REMU give DATA1.
  - Signed overflow (DIV/REM, DATA1=0x80000000, DATA2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Normal path:
  - Accept edge N: go to CALC, counter=0, remainder register=0, quotient register=|dividend|.
  - Each CALC edge: shift {rem,quo} left by 1, trial-subtract |divisor| from rem; if non-negative, keep the difference and set quo[0]=1. Counter increments.
  - After 32 steps (edge N+32), go to FIX.
  - Edge N+33: apply sign correction, select quotient (DIV/DIVU) or remainder (REM/REMU) into RESULT, go to DONE.
  - DONE is high in the cycle after edge N+33, giving a fixed latency of 33 cycles.
- DONE state lasts exactly one cycle, then IDLE. A new START may be accepted on the first IDLE edge; back-to-back issue costs one IDLE cycle.
- KILL: when high on any edge with state not IDLE, go to IDLE. DONE is not asserted, and RESULT keeps its prior value. KILL has priority over START and over DONE entry; START is ignored while KILL=1.
- Arithmetic:
  - The trial subtract is WIDTH+1 bits wide, so no overflow is lost.
  - Negation is two's complement on WIDTH bits.
  - Unsigned ops never negate.
- BUSY is a registered function of state: 1 in CALC, FIX and DONE.

Decomposition:
- Shared package `div_pkg`:
  - OP encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU).
  - State enum (S_IDLE, S_CALC, S_FIX, S_DONE).
  - WIDTH default and the all-ones and minimum-signed constants.
- Sub-module `div_step`: a combinational single restoring iteration. It takes rem, quo and divisor and returns the next rem and quo, so the step can be unit-tested and later unrolled to radix-4.

Test Plan:
- DIV 20/3 -> RESULT=6, DONE exactly 33 cycles after accept; REM 20/3 -> 2.
- DIV -20/3 (0xFFFFFFEC/3) -> 0xFFFFFFFA; REM -> 0xFFFFFFFE; REMU 0xFFFFFFEC/3 -> 0x2; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
- Divide by zero: DIV 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DONE one cycle after accept; BUSY high for one cycle only.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; latency 1.
- Control:
  - START pulsed at cycle 10 of CALC -> ignored, and the first result is unchanged.
  - KILL at cycle 15 -> IDLE next edge with no DONE pulse.
  - KILL and START together in IDLE -> no accept.
- RESET asserted at CALC cycle 20 -> next cycle BUSY=0, DONE=0, RESULT=0. A following DIVU 100/7 -> 14 with normal latency.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: operation codes, FSM states
// and the width-dependent constants used by the special-case paths.
package div_pkg;

   localparam int unsigned DIV_WIDTH = 32;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES   = '1;
   localparam logic [DIV_WIDTH-1:0] DIV_MIN_SIGNED = {1'b1, {(DIV_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring iteration: shift {rem,quo} left by one,
// trial-subtract the divisor magnitude and keep the difference when it fits.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           fits;

   // Trial subtract on WIDTH+1 bits. Because rem < dvs on entry, a successful
   // subtract always leaves a value below 2^WIDTH, while a borrow always sets
   // the top bit, so trial[WIDTH] alone tells whether the divisor fitted.
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      trial    = shifted - {1'b0, dvs};
      fits     = ~trial[WIDTH];
      rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU). Signed operands are reduced
// to magnitudes on accept, one quotient bit is produced per CALC cycle, and
// the FIX cycle restores signs and selects quotient or remainder.
module div_unit
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = 5
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [1:0]       OP,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   input  logic             KILL,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT
);

   localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       state;
   div_state_t       state_next;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             neg_q;
   logic             neg_r;
   logic             rem_sel;

   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;

   logic             accept;
   logic             is_signed;
   logic             is_rem;
   logic             div_zero;
   logic             overflow;
   logic             special;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;
   logic [WIDTH-1:0] fixed_q;
   logic [WIDTH-1:0] fixed_r;

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem     (rem),
      .quo     (quo),
      .dvs     (dvs),
      .rem_next(rem_next),
      .quo_next(quo_next)
   );

   // Decode the incoming request, operand magnitudes and the sign-fixed results.
   always_comb begin
      accept    = (state == S_IDLE) && START && !KILL;
      is_signed = ~OP[0];
      is_rem    = OP[1];
      div_zero  = (DATA2 == '0);
      overflow  = is_signed && (DATA1 == MIN_S) && (DATA2 == '1);
      special   = div_zero || overflow;
      mag1      = (is_signed && DATA1[WIDTH-1]) ? (~DATA1 + 1'b1) : DATA1;
      mag2      = (is_signed && DATA2[WIDTH-1]) ? (~DATA2 + 1'b1) : DATA2;
      fixed_q   = neg_q ? (~quo + 1'b1) : quo;
      fixed_r   = neg_r ? (~rem + 1'b1) : rem;
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and status outputs; KILL overrides every non-idle transition.
   always_comb begin
      state_next = state;
      BUSY       = (state != S_IDLE);
      DONE       = (state == S_DONE);
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_next = special ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (KILL) begin
               state_next = S_IDLE;
            end else if (cnt == '1) begin
               state_next = S_FIX;
            end
         end
         S_FIX: begin
            state_next = KILL ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: latch operands on accept, iterate in CALC, publish in FIX.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         rem_sel <= 1'b0;
         RESULT  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  rem_sel <= is_rem;
                  if (div_zero) begin
                     RESULT <= is_rem ? DATA1 : '1;
                  end else if (overflow) begin
                     RESULT <= is_rem ? '0 : MIN_S;
                  end else begin
                     cnt   <= '0;
                     rem   <= '0;
                     quo   <= mag1;
                     dvs   <= mag2;
                     neg_q <= is_signed && (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
                     neg_r <= is_signed && DATA1[WIDTH-1];
                  end
               end
            end
            S_CALC: begin
               if (!KILL) begin
                  rem <= rem_next;
                  quo <= quo_next;
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_FIX: begin
               if (!KILL) begin
                  RESULT <= rem_sel ? fixed_r : fixed_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
